demux_1_8_deser: RTL and testbench

DEMUX_1_8_DESER -- requirements
Module: demux_1_8_deser

---
 rtl/demux_1_8_deser_pkg.sv | 13 +
 rtl/demux_1_8_deser.sv | 93 +++++++++
 tb/tb_demux_1_8_deser.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_8_deser_pkg.sv
// Shared definitions for the 1:8 serial-to-parallel demultiplexer.
// Holds the FSM encoding and the fixed frame geometry.
package demux_1_8_deser_pkg;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1_8_deser.sv
// 1:8 deserializer: rebuilds an LSB-first 8-bit frame from a serial stream
// framed by i_start, with a one-deep output register and backpressure.
module demux_1_8_deser
    import demux_1_8_deser_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_f,
    input  logic                 i_valid,
    input  logic                 i_start,
    output logic                 o_ready,
    output logic [FRAME_LEN-1:0] o_code,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CNT_W-1:0]     o_sel_code,
    output logic                 o_err
);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [FRAME_LEN-1:0] r_shadow;
    logic [FRAME_LEN-1:0] r_code;
    logic                 r_valid;
    logic                 r_err;

    logic w_last;
    logic w_ready;
    logic w_accept;
    logic w_consume;

    assign w_last    = (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_accept  = i_valid & w_ready;
    assign w_consume = r_valid & i_ready;

    // Stall only the final bit: it would overwrite a frame nobody has taken yet.
    always_comb begin
        w_ready = 1'b1;
        if ((r_state == ST_RECV) && w_last && r_valid && !i_ready) begin
            w_ready = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_consume) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_shadow <= {{(FRAME_LEN-1){1'b0}}, i_f};
                            r_cnt    <= CNT_W'(1);
                            r_state  <= ST_RECV;
                        end
                    end
                    ST_RECV: begin
                        if (i_start) begin
                            // Resync: drop the partial frame, this bit is a new bit 0.
                            r_err    <= 1'b1;
                            r_shadow <= {{(FRAME_LEN-1){1'b0}}, i_f};
                            r_cnt    <= CNT_W'(1);
                        end else if (w_last) begin
                            r_code  <= {i_f, r_shadow[FRAME_LEN-2:0]};
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_shadow[r_cnt] <= i_f;
                            r_cnt           <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_ready    = w_ready;
    assign o_code     = r_code;
    assign o_valid    = r_valid;
    assign o_sel_code = r_cnt;
    assign o_err      = r_err;

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Scoreboard bench for demux_1_8_deser: a bit-queue frame model predicts
// each delivered frame, error pulse, ready and channel index.
module tb_demux_1_8_deser;

  logic       clk;
  logic       i_rst_n;
  logic       i_f;
  logic       i_valid;
  logic       i_start;
  logic       o_ready;
  logic [7:0] o_code;
  logic       o_valid;
  logic       i_ready;
  logic [2:0] o_sel_code;
  logic       o_err;

  demux_1_8_deser dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_f        (i_f),
    .i_valid    (i_valid),
    .i_start    (i_start),
    .o_ready    (o_ready),
    .o_code     (o_code),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sel_code (o_sel_code),
    .o_err      (o_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // reference model: bits of the frame being collected, output slot, error flag
  int         m_bits[$];
  bit         m_coll  = 1'b0;
  bit         m_full  = 1'b0;
  bit         m_err   = 1'b0;
  logic [7:0] exp_q[$];
  int         rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit         gaps_on  = 1'b0;
  logic [7:0] mon_e;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mux8(input logic [7:0] d, input int sel);
    return d[sel];
  endfunction

  // one clock cycle of stimulus; model advances on the edge
  task automatic cycle(input bit v, input bit f, input bit s, output bit acc);
    bit r;
    bit er;
    bit done;
    logic [7:0] code;
    r = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    i_ready = r;
    i_valid = v;
    i_f     = f;
    i_start = s;
    @(negedge clk);
    er = !(m_coll && m_bits.size() == 7 && m_full && !r);
    chk("o_ready", {7'd0, o_ready}, {7'd0, er});
    chk("o_valid", {7'd0, o_valid}, {7'd0, m_full});
    chk("o_sel_code", {5'd0, o_sel_code}, m_coll ? 8'(m_bits.size()) : 8'd0);
    chk("o_err", {7'd0, o_err}, {7'd0, m_err});
    @(posedge clk);
    acc   = v && er;
    done  = 1'b0;
    m_err = 1'b0;
    if (acc) begin
      if (s) begin
        m_err = m_coll;
        m_bits.delete();
        m_bits.push_back(int'(f));
        m_coll = 1'b1;
      end else if (m_coll) begin
        m_bits.push_back(int'(f));
        if (m_bits.size() == 8) begin
          code = 8'd0;
          for (int i = 0; i < 8; i++) code = code + 8'(m_bits[i] << i);
          exp_q.push_back(code);
          m_bits.delete();
          m_coll = 1'b0;
          done   = 1'b1;
        end
      end
    end
    if (done) m_full = 1'b1;
    else if (m_full && r) m_full = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
  endtask

  // send bits lo..hi of code, i_start on bit 0; retries while stalled
  task automatic send_bits(input logic [7:0] code, input int lo, input int hi);
    bit acc;
    int tries;
    for (int i = lo; i <= hi; i++) begin
      if (gaps_on && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 64) begin
        cycle(1'b1, mux8(code, i), (i == 0), acc);
        tries++;
      end
      if (!acc) chk("accept_timeout", 8'd0, 8'd1);
    end
  endtask

  task automatic send_frame(input logic [7:0] code);
    send_bits(code, 0, 7);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    chk("rst_o_code", o_code, 8'h00);
    chk("rst_o_valid", {7'd0, o_valid}, 8'd0);
    chk("rst_o_err", {7'd0, o_err}, 8'd0);
    chk("rst_o_sel_code", {5'd0, o_sel_code}, 8'd0);
    chk("rst_o_ready", {7'd0, o_ready}, 8'd1);
    m_bits.delete();
    exp_q.delete();
    m_coll = 1'b0;
    m_full = 1'b0;
    m_err  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: compare on every output handshake
  always @(negedge clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got %h expected none at %0t", o_code, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame_code", o_code, mon_e);
      end
    end
  end

  initial begin
    bit acc;
    int tries;
    i_rst_n = 1'b0;
    i_f = 1'b0; i_valid = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // single frame 0xA5, always ready
    rdy_mode = 1;
    send_frame(8'hA5);
    chk("a5_code", o_code, 8'hA5);
    chk("a5_valid", {7'd0, o_valid}, 8'd1);
    chk("a5_sel_back_to_0", {5'd0, o_sel_code}, 8'd0);
    idle(2);

    // back-to-back 0x3C / 0xC3 with backpressure on the final bit
    rdy_mode = 0;
    send_frame(8'h3C);
    send_bits(8'hC3, 0, 6);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b1, 1'b0, acc);
      chk("bp_stall", {7'd0, acc}, 8'd0);
      chk("bp_hold_code", o_code, 8'h3C);
    end
    rdy_mode = 1;
    cycle(1'b1, 1'b1, 1'b0, acc);
    chk("bp_release_acc", {7'd0, acc}, 8'd1);
    chk("nobubble_valid", {7'd0, o_valid}, 8'd1);
    chk("nobubble_code", o_code, 8'hC3);
    idle(2);

    // restart mid-frame at cnt==4, then 0x0F
    send_bits(8'h5A, 0, 3);
    chk("pre_err_sel", {5'd0, o_sel_code}, 8'd4);
    send_frame(8'h0F);
    chk("resync_code", o_code, 8'h0F);
    idle(2);

    // reset at cnt==5, then 0xFF
    send_bits(8'h33, 0, 4);
    do_reset();
    send_bits(8'hFF, 1, 7);
    chk("no_frame_without_start", {7'd0, o_valid}, 8'd0);
    send_frame(8'hFF);
    chk("post_reset_code", o_code, 8'hFF);
    idle(2);

    // leading bits without start ignored, then 0x81 with gaps
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, acc);
    chk("idle_discard_sel", {5'd0, o_sel_code}, 8'd0);
    gaps_on = 1'b1;
    send_frame(8'h81);
    chk("gap_code", o_code, 8'h81);
    idle(2);

    // loopback of every code through an 8:1 mux model, random ready and gaps
    rdy_mode = 2;
    for (int c = 0; c < 256; c++) send_frame(8'(c));

    // drain
    rdy_mode = 1;
    gaps_on  = 1'b0;
    tries    = 0;
    while (exp_q.size() != 0 && tries < 20) begin
      idle(1);
      tries++;
    end
    chk("drain_empty", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
